// File: rtl/step_dir_decoder_pkg.sv
// Shared types and parameter defaults for the step/direction decoder.
package step_dir_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DIR_SETUP_DEF   = 4;
  localparam int MIN_HIGH_DEF    = 2;

  typedef enum logic {
    S_LOW  = 1'b0,
    S_HIGH = 1'b1
  } pulse_state_e;

  // Free-running cycle counter step that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/step_dir_decoder_if.sv
// Step/direction pins, control strobes and decoded results as a single bundle.
interface step_dir_decoder_if;

  logic               step;
  logic               direction;
  logic               enable_n;
  logic               preset_load;
  logic signed [31:0] preset_value;
  logic               clear_errors;

  logic signed [31:0] position;
  logic [31:0]        step_count;
  logic [31:0]        last_period;
  logic               period_valid;
  logic               step_strobe;
  logic               dir_setup_error;
  logic               pulse_width_error;
  logic               disabled_step_error;

  modport master (
    output step, direction, enable_n, preset_load, preset_value, clear_errors,
    input  position, step_count, last_period, period_valid, step_strobe,
    input  dir_setup_error, pulse_width_error, disabled_step_error
  );

  modport slave (
    input  step, direction, enable_n, preset_load, preset_value, clear_errors,
    output position, step_count, last_period, period_valid, step_strobe,
    output dir_setup_error, pulse_width_error, disabled_step_error
  );

endinterface

// File: rtl/step_dir_decoder_step_sync.sv
// N-flop synchronizer with rise/fall detect. Rises are suppressed until the input has
// been seen low after reset, so a pin already high at reset release never counts as an edge.
module step_sync
  import step_dir_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic [STAGES-1:0] fill;
  logic              prev;
  logic              armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
      fill  <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      fill  <= {fill[STAGES-2:0], 1'b1};
      prev  <= level;
      // Only trust a low once the chain holds real samples rather than reset zeros.
      if (fill[STAGES-1] && !level) begin
        armed <= 1'b1;
      end
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = armed & level & ~prev;
  assign fall  = prev & ~level;

endmodule

// File: rtl/step_dir_decoder.sv
// Decodes a step/direction pulse train into position, step count and step period,
// with sticky flags for direction setup, short pulses and steps while disabled.
module step_dir_decoder
  import step_dir_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DIR_SETUP   = DIR_SETUP_DEF,
  parameter int MIN_HIGH    = MIN_HIGH_DEF
) (
  input logic               clk,
  input logic               reset,
  step_dir_decoder_if.slave bus
);

  localparam int               AGE_W    = $clog2(DIR_SETUP + 1);
  localparam int               HIGH_W   = $clog2(MIN_HIGH + 1);
  localparam logic [AGE_W-1:0]  AGE_MAX  = AGE_W'(DIR_SETUP);
  localparam logic [HIGH_W-1:0] HIGH_MAX = HIGH_W'(MIN_HIGH);

  logic step_lvl, step_rise, step_fall;
  logic dir_lvl, dir_rise, dir_fall;
  logic en_lvl, en_rise, en_fall;
  logic unused_sync;

  pulse_state_e state, state_nxt;

  logic [AGE_W-1:0]  dir_age;
  logic [HIGH_W-1:0] high_cnt;

  logic step_accept;
  logic step_blocked;
  logic width_short;
  logic dir_short;

  logic signed [31:0] position_q;
  logic [31:0]        step_count_q;
  logic [31:0]        last_period_q;
  logic [31:0]        period_cnt;
  logic               seen_step;
  logic               period_valid_q;
  logic               step_strobe_q;
  logic               dir_err_q;
  logic               width_err_q;
  logic               dis_err_q;

  step_sync #(.STAGES(SYNC_STAGES)) u_step_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.step),
    .level (step_lvl),
    .rise  (step_rise),
    .fall  (step_fall)
  );

  step_sync #(.STAGES(SYNC_STAGES)) u_dir_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.direction),
    .level (dir_lvl),
    .rise  (dir_rise),
    .fall  (dir_fall)
  );

  step_sync #(.STAGES(SYNC_STAGES)) u_en_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.enable_n),
    .level (en_lvl),
    .rise  (en_rise),
    .fall  (en_fall)
  );

  assign unused_sync = step_lvl | en_rise | en_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_LOW;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    step_accept  = 1'b0;
    step_blocked = 1'b0;
    width_short  = 1'b0;
    dir_short    = 1'b0;
    case (state)
      S_LOW: begin
        if (step_rise) begin
          state_nxt    = S_HIGH;
          step_accept  = ~en_lvl;
          step_blocked = en_lvl;
          // A direction edge in the same cycle as the step edge counts as zero setup.
          dir_short    = ~en_lvl & (dir_rise | dir_fall | (dir_age < AGE_MAX));
        end
      end
      S_HIGH: begin
        if (step_fall) begin
          state_nxt   = S_LOW;
          width_short = (high_cnt < HIGH_MAX);
        end
      end
      default: state_nxt = S_LOW;
    endcase
  end

  // Cycles since the synchronized direction last changed, saturating at DIR_SETUP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_age <= AGE_MAX;
    end else if (dir_rise || dir_fall) begin
      dir_age <= AGE_W'(1);
    end else if (dir_age != AGE_MAX) begin
      dir_age <= dir_age + 1'b1;
    end
  end

  // Dwell in S_HIGH, saturating at MIN_HIGH; equals the high width at the falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_cnt <= '0;
    end else if (state == S_LOW) begin
      high_cnt <= step_rise ? HIGH_W'(1) : '0;
    end else if (high_cnt != HIGH_MAX) begin
      high_cnt <= high_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      position_q     <= '0;
      step_count_q   <= '0;
      last_period_q  <= '0;
      period_cnt     <= '0;
      seen_step      <= 1'b0;
      period_valid_q <= 1'b0;
      step_strobe_q  <= 1'b0;
    end else begin
      step_strobe_q <= step_accept;
      period_cnt    <= step_accept ? 32'd1 : sat_inc32(period_cnt);

      if (step_accept) begin
        step_count_q  <= step_count_q + 32'd1;
        last_period_q <= period_cnt;
      end

      if (bus.preset_load) begin
        position_q <= bus.preset_value;
      end else if (step_accept) begin
        position_q <= dir_lvl ? position_q - 32'sd1 : position_q + 32'sd1;
      end

      // A preset restarts the "two steps seen" qualification for the period.
      if (bus.preset_load) begin
        seen_step      <= 1'b0;
        period_valid_q <= 1'b0;
      end else if (step_accept) begin
        seen_step <= 1'b1;
        if (seen_step) begin
          period_valid_q <= 1'b1;
        end
      end
    end
  end

  // Sticky flags: a new event in the clearing cycle leaves the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_err_q   <= 1'b0;
      width_err_q <= 1'b0;
      dis_err_q   <= 1'b0;
    end else begin
      dir_err_q   <= (dir_err_q & ~bus.clear_errors) | dir_short;
      width_err_q <= (width_err_q & ~bus.clear_errors) | width_short;
      dis_err_q   <= (dis_err_q & ~bus.clear_errors) | step_blocked;
    end
  end

  assign bus.position            = position_q;
  assign bus.step_count          = step_count_q;
  assign bus.last_period         = last_period_q;
  assign bus.period_valid        = period_valid_q;
  assign bus.step_strobe         = step_strobe_q;
  assign bus.dir_setup_error     = dir_err_q;
  assign bus.pulse_width_error   = width_err_q;
  assign bus.disabled_step_error = dis_err_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed and randomized step pulses checked against an event-level model of the decoder.
module tb_step_dir_decoder;

  localparam int N         = 2;
  localparam int DIR_SETUP = 4;
  localparam int MIN_HIGH  = 2;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   cyc;

  step_dir_decoder_if bus ();

  step_dir_decoder #(
    .SYNC_STAGES (N),
    .DIR_SETUP   (DIR_SETUP),
    .MIN_HIGH    (MIN_HIGH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, kept in terms of pulses and cycle stamps.
  logic signed [31:0] m_pos;
  logic [31:0]        m_cnt;
  logic [31:0]        m_last;
  bit                 m_last_known;
  int                 m_prev_acc_cyc;
  int                 m_since_preset;
  bit                 m_dir;
  int                 m_dir_cyc;
  bit                 m_dir_err, m_pw_err, m_dis_err;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic bit flag_after(input bit old, input int ev, input int clr_j);
    if (ev >= 0 && (clr_j < 0 || ev >= clr_j)) return 1'b1;
    if (clr_j >= 0) return 1'b0;
    return old;
  endfunction

  task automatic model_reset();
    m_pos          = '0;
    m_cnt          = '0;
    m_last         = '0;
    m_last_known   = 1'b1;
    m_prev_acc_cyc = -1;
    m_since_preset = 0;
    m_dir_cyc      = -1000;
    m_dir_err      = 1'b0;
    m_pw_err       = 1'b0;
    m_dis_err      = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pos"}, bus.position, m_pos);
    chk({tag, "_cnt"}, bus.step_count, m_cnt);
    if (m_last_known) chk({tag, "_last"}, bus.last_period, m_last);
    chk({tag, "_pvld"}, {31'd0, bus.period_valid}, {31'd0, m_since_preset >= 2});
    chk({tag, "_dir_err"}, {31'd0, bus.dir_setup_error}, {31'd0, m_dir_err});
    chk({tag, "_pw_err"}, {31'd0, bus.pulse_width_error}, {31'd0, m_pw_err});
    chk({tag, "_dis_err"}, {31'd0, bus.disabled_step_error}, {31'd0, m_dis_err});
  endtask

  // One step pulse: direction/enable applied 'pre' cycles before the rise, then 'high'
  // cycles high and 'low' cycles low. preset_j / clr_j strobe those inputs in that cycle
  // counted from the rise (-1 = none).
  task automatic pulse(input bit dir, input bit en_n, input int pre, input int high,
                       input int low, input int preset_j, input logic signed [31:0] pv,
                       input int clr_j);
    int r;
    bit acc;
    int ev_dir, ev_pw, ev_dis;
    if (dir != m_dir) begin
      bus.direction = dir;
      m_dir         = dir;
      m_dir_cyc     = cyc;
    end
    bus.enable_n = en_n;
    repeat (pre) tick();
    r      = cyc;
    acc    = !en_n;
    ev_dir = (acc && (r - m_dir_cyc) < DIR_SETUP) ? N : -1;
    ev_dis = acc ? -1 : N;
    ev_pw  = (high < MIN_HIGH) ? high + N : -1;
    for (int j = 0; j < high + low; j++) begin
      bus.step         = (j < high);
      bus.preset_load  = (j == preset_j);
      bus.preset_value = pv;
      bus.clear_errors = (j == clr_j);
      tick();
      chk("strobe", {31'd0, bus.step_strobe}, {31'd0, acc && (j == N)});
    end
    bus.preset_load  = 1'b0;
    bus.clear_errors = 1'b0;

    if (acc) begin
      m_cnt = m_cnt + 32'd1;
      if (m_prev_acc_cyc >= 0) begin
        m_last       = 32'(r - m_prev_acc_cyc);
        m_last_known = 1'b1;
      end else begin
        m_last_known = 1'b0;
      end
      m_prev_acc_cyc = r;
    end
    if (preset_j >= 0 && preset_j < N) begin
      m_pos          = pv;
      m_since_preset = 0;
    end
    if (preset_j == N) begin
      m_pos          = pv;
      m_since_preset = 0;
    end else if (acc) begin
      m_pos          = dir ? m_pos - 32'sd1 : m_pos + 32'sd1;
      m_since_preset = m_since_preset + 1;
    end
    if (preset_j > N) begin
      m_pos          = pv;
      m_since_preset = 0;
    end
    m_dir_err = flag_after(m_dir_err, ev_dir, clr_j);
    m_pw_err  = flag_after(m_pw_err, ev_pw, clr_j);
    m_dis_err = flag_after(m_dis_err, ev_dis, clr_j);
  endtask

  task automatic do_preset(input logic signed [31:0] pv);
    bus.preset_load  = 1'b1;
    bus.preset_value = pv;
    tick();
    bus.preset_load  = 1'b0;
    m_pos            = pv;
    m_since_preset   = 0;
  endtask

  task automatic do_clear();
    bus.clear_errors = 1'b1;
    tick();
    bus.clear_errors = 1'b0;
    m_dir_err = 1'b0;
    m_pw_err  = 1'b0;
    m_dis_err = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pos"}, bus.position, 32'd0);
    chk({tag, "_cnt"}, bus.step_count, 32'd0);
    chk({tag, "_last"}, bus.last_period, 32'd0);
    chk({tag, "_pvld"}, {31'd0, bus.period_valid}, 32'd0);
    chk({tag, "_strobe"}, {31'd0, bus.step_strobe}, 32'd0);
    chk({tag, "_errs"}, {29'd0, bus.dir_setup_error, bus.pulse_width_error,
                         bus.disabled_step_error}, 32'd0);
  endtask

  initial begin
    bit                 d, en;
    int                 pre, hi, lo, pj, cj;
    logic signed [31:0] pv;

    vectors          = 0;
    miscompares      = 0;
    cyc              = 0;
    reset            = 1'b0;
    bus.step         = 1'b0;
    bus.direction    = 1'b0;
    bus.enable_n     = 1'b0;
    bus.preset_load  = 1'b0;
    bus.preset_value = '0;
    bus.clear_errors = 1'b0;
    m_dir            = 1'b0;
    model_reset();

    repeat (3) tick();
    check_reset_state("reset");
    reset = 1'b1;
    repeat (6) tick();

    // Ten 4-high/4-low pulses, direction 0.
    for (int i = 0; i < 10; i++) begin
      pulse(1'b0, 1'b0, 1, 4, 3, -1, '0, -1);
      check_all("fwd");
    end
    chk("fwd10_pos", bus.position, 32'd10);
    chk("fwd10_cnt", bus.step_count, 32'd10);
    chk("fwd10_last", bus.last_period, 32'd8);
    chk("fwd10_pvld", {31'd0, bus.period_valid}, 32'd1);

    // Reverse from a zero preset.
    do_preset(32'sd0);
    chk("preset0_pos", bus.position, 32'd0);
    chk("preset0_pvld", {31'd0, bus.period_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0, 6, 4, 3, -1, '0, -1);
      check_all("rev");
    end
    chk("rev3_pos", bus.position, 32'hFFFF_FFFD);
    chk("rev3_cnt", bus.step_count, 32'd13);

    // Signed wrap at the positive limit.
    do_preset(32'sh7FFF_FFFF);
    pulse(1'b0, 1'b0, 6, 4, 3, -1, '0, -1);
    check_all("wrap");
    chk("wrap_pos", bus.position, 32'h8000_0000);

    // Direction changed two cycles before the step edge.
    pulse(1'b1, 1'b0, 2, 4, 3, -1, '0, -1);
    check_all("dsetup");
    chk("dsetup_flag", {31'd0, bus.dir_setup_error}, 32'd1);
    do_clear();
    chk("dsetup_clr", {31'd0, bus.dir_setup_error}, 32'd0);

    // Step while disabled, then a one-cycle-high step.
    pulse(1'b1, 1'b1, 6, 4, 3, -1, '0, -1);
    check_all("disabled");
    chk("disabled_flag", {31'd0, bus.disabled_step_error}, 32'd1);
    do_clear();
    pulse(1'b1, 1'b0, 6, 1, 4, -1, '0, -1);
    check_all("narrow");
    chk("narrow_flag", {31'd0, bus.pulse_width_error}, 32'd1);
    do_clear();

    // Preset landing on the same cycle as an accepted step, then two more steps.
    pulse(1'b0, 1'b0, 6, 4, 3, N, 32'sh1234_5678, -1);
    check_all("preset_step");
    chk("preset_step_pos", bus.position, 32'h1234_5678);
    pulse(1'b0, 1'b0, 1, 4, 3, -1, '0, -1);
    check_all("preset_step_a");
    pulse(1'b0, 1'b0, 1, 4, 3, -1, '0, -1);
    check_all("preset_step_b");

    // Clear strobes landing on the cycle an error is detected.
    pulse(1'b0, 1'b0, 1, 1, 4, -1, '0, 1 + N);
    check_all("clr_vs_pw");
    pulse(1'b1, 1'b0, 1, 4, 3, -1, '0, N);
    check_all("clr_vs_dir");
    do_clear();

    // Random pulse trains.
    for (int p = 0; p < 150; p++) begin
      d   = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 7) == 0);
      pre = int'($urandom_range(1, 8));
      hi  = int'($urandom_range(1, 6));
      lo  = int'($urandom_range(N + 1, 6));
      pv  = $urandom;
      if ($urandom_range(0, 9) == 0) pj = int'($urandom_range(0, hi + lo - 1));
      else pj = -1;
      if ($urandom_range(0, 7) == 0) cj = int'($urandom_range(0, hi + lo - 1));
      else cj = -1;
      pulse(d, en, pre, hi, lo, pj, pv, cj);
      check_all("rand");
    end

    // Reset in the middle of a pulse; the still-high pin must not count after release.
    bus.enable_n = 1'b0;
    bus.step     = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    model_reset();
    tick();
    check_reset_state("midreset");
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midreset_strobe", {31'd0, bus.step_strobe}, 32'd0);
    end
    chk("midreset_cnt", bus.step_count, 32'd0);
    bus.step = 1'b0;
    repeat (4) tick();
    pulse(m_dir, 1'b0, 1, 4, 3, -1, '0, -1);
    check_all("after_reset");
    chk("after_reset_cnt", bus.step_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
